axis_crc32_check: RTL and testbench

//  Downstream consumer of the AXI-Stream CRC32/MPEG-2 engine. Joins the engine's CRC output stream with a

---
 rtl/axis_crc32_check.sv | 117 +++++++++++
 tb/tb_axis_crc32_check.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_crc32_check.sv
// Joins a computed-CRC stream with a reference-CRC stream, compares each pair and emits one
// status word per pair, while keeping saturating match/mismatch counters and a sticky error flag.
module axis_crc32_check #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CRC_WIDTH      = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      clr,

    input  logic [AXI_DATA_WIDTH-1:0] s_crc_tdata,
    input  logic                      s_crc_tvalid,
    output logic                      s_crc_tready,

    input  logic [AXI_DATA_WIDTH-1:0] s_ref_tdata,
    input  logic                      s_ref_tvalid,
    output logic                      s_ref_tready,

    output logic [31:0]               m_sts_tdata,
    output logic                      m_sts_tvalid,
    input  logic                      m_sts_tready,

    output logic [CNT_WIDTH-1:0]      match_cnt,
    output logic [CNT_WIDTH-1:0]      mismatch_cnt,
    output logic                      err_sticky
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          sts_q, sts_d;
    logic [CNT_WIDTH-1:0] match_q, match_d;
    logic [CNT_WIDTH-1:0] mismatch_q, mismatch_d;
    logic [CNT_WIDTH-1:0] seq_q, seq_d;
    logic                 err_q, err_d;

    logic                 fire;
    logic                 mismatch;

    // Gating with aresetn keeps both treadys low while the block is held in reset.
    assign fire = aresetn & s_crc_tvalid & s_ref_tvalid & ((state_q == EMPTY) | m_sts_tready);
    assign mismatch = (s_crc_tdata[CRC_WIDTH-1:0] != s_ref_tdata[CRC_WIDTH-1:0]);

    assign s_crc_tready = fire;
    assign s_ref_tready = fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (fire) state_d = FULL;
            FULL:    if (m_sts_tready && !fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // The status word always carries the pre-clear sequence number, even when clr lands on a fire.
    always_comb begin
        sts_d = sts_q;
        if (fire) begin
            sts_d                  = '0;
            sts_d[CNT_WIDTH-1:0]   = seq_q;
            sts_d[31]              = mismatch;
        end
    end

    always_comb begin
        match_d    = match_q;
        mismatch_d = mismatch_q;
        seq_d      = seq_q;
        err_d      = err_q;
        if (clr) begin
            match_d    = '0;
            mismatch_d = '0;
            seq_d      = '0;
            err_d      = 1'b0;
        end else if (fire) begin
            seq_d = seq_q + 1'b1;
            if (mismatch) begin
                err_d = 1'b1;
                if (mismatch_q != CNT_MAX) mismatch_d = mismatch_q + 1'b1;
            end else begin
                if (match_q != CNT_MAX) match_d = match_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= EMPTY;
            sts_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            seq_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sts_q      <= sts_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            seq_q      <= seq_d;
            err_q      <= err_d;
        end
    end

    assign m_sts_tvalid = (state_q == FULL);
    assign m_sts_tdata  = sts_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mismatch_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_axis_crc32_check.sv
// Randomized bench for axis_crc32_check: sources and sink are driven with random handshakes and
// every output is compared each cycle against a queue-based reference model of the pair join.
module tb_axis_crc32_check;

    logic        aclk;
    logic        aresetn;
    logic        clr;
    logic [31:0] s_crc_tdata;
    logic        s_crc_tvalid;
    logic        s_crc_tready;
    logic [31:0] s_ref_tdata;
    logic        s_ref_tvalid;
    logic        s_ref_tready;
    logic [31:0] m_sts_tdata;
    logic        m_sts_tvalid;
    logic        m_sts_tready;
    logic [15:0] match_cnt;
    logic [15:0] mismatch_cnt;
    logic        err_sticky;

    axis_crc32_check #(
        .AXI_DATA_WIDTH(32),
        .CRC_WIDTH(32),
        .CNT_WIDTH(16)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .clr(clr),
        .s_crc_tdata(s_crc_tdata),
        .s_crc_tvalid(s_crc_tvalid),
        .s_crc_tready(s_crc_tready),
        .s_ref_tdata(s_ref_tdata),
        .s_ref_tvalid(s_ref_tvalid),
        .s_ref_tready(s_ref_tready),
        .m_sts_tdata(m_sts_tdata),
        .m_sts_tvalid(m_sts_tvalid),
        .m_sts_tready(m_sts_tready),
        .match_cnt(match_cnt),
        .mismatch_cnt(mismatch_cnt),
        .err_sticky(err_sticky)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Pending pairs (front is what both sources present) and statuses the DUT owes the sink.
    logic [31:0] pair_crc[$];
    logic [31:0] pair_ref[$];
    logic [31:0] exp_sts[$];
    int          m_match;
    int          m_mismatch;
    int          m_seq;
    int          m_err;

    int crc_pct, ref_pct, rdy_pct, mm_pct, clr_pm;
    bit fire_s, drain_s, clr_s;
    int hang_cnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setKnobs(input int c, input int r, input int k, input int m, input int cl);
        crc_pct = c; ref_pct = r; rdy_pct = k; mm_pct = m; clr_pm = cl;
    endtask

    task automatic genPair();
        logic [31:0] c;
        logic [31:0] r;
        c = $urandom;
        r = c;
        if ($urandom_range(99) < mm_pct) r = c ^ (32'h1 << $urandom_range(31));
        pair_crc.push_back(c);
        pair_ref.push_back(r);
    endtask

    task automatic forcePair(input logic [31:0] c, input logic [31:0] r);
        pair_crc.push_back(c);
        pair_ref.push_back(r);
    endtask

    task automatic flushModel();
        pair_crc.delete();
        pair_ref.delete();
        exp_sts.delete();
        m_match = 0; m_mismatch = 0; m_seq = 0; m_err = 0;
        s_crc_tvalid = 1'b0;
        s_ref_tvalid = 1'b0;
    endtask

    task automatic driveInputs();
        if (!s_crc_tvalid && ($urandom_range(99) < crc_pct)) begin
            if (pair_crc.size() == 0) genPair();
            s_crc_tvalid = 1'b1;
            s_crc_tdata  = pair_crc[0];
        end
        if (!s_ref_tvalid && ($urandom_range(99) < ref_pct)) begin
            if (pair_ref.size() == 0) genPair();
            s_ref_tvalid = 1'b1;
            s_ref_tdata  = pair_ref[0];
        end
        m_sts_tready = ($urandom_range(99) < rdy_pct);
        clr          = ($urandom_range(999) < clr_pm);
    endtask

    task automatic checkCycle();
        bit full;
        full    = (exp_sts.size() != 0);
        fire_s  = s_crc_tvalid && s_ref_tvalid && (!full || m_sts_tready);
        drain_s = full && m_sts_tready;
        clr_s   = clr;
        checkOutput("crc_tready", {31'b0, s_crc_tready}, {31'b0, fire_s});
        checkOutput("ref_tready", {31'b0, s_ref_tready}, {31'b0, fire_s});
        checkOutput("sts_tvalid", {31'b0, m_sts_tvalid}, {31'b0, full});
        if (full) checkOutput("sts_tdata", m_sts_tdata, exp_sts[0]);
        checkOutput("match_cnt", {16'b0, match_cnt}, m_match);
        checkOutput("mismatch_cnt", {16'b0, mismatch_cnt}, m_mismatch);
        checkOutput("err_sticky", {31'b0, err_sticky}, m_err);
        if (s_crc_tvalid && s_ref_tvalid && m_sts_tready && !s_crc_tready) hang_cnt++;
        else hang_cnt = 0;
        if (hang_cnt >= 20) begin
            checkOutput("hang_watchdog", hang_cnt, 0);
            hang_cnt = 0;
        end
    endtask

    task automatic updateModel();
        logic [31:0] sts;
        bit mm;
        if (drain_s) void'(exp_sts.pop_front());
        if (fire_s) begin
            mm  = (pair_crc[0] != pair_ref[0]);
            sts = (mm ? 32'h8000_0000 : 32'h0) | (m_seq & 32'hFFFF);
            exp_sts.push_back(sts);
            void'(pair_crc.pop_front());
            void'(pair_ref.pop_front());
            s_crc_tvalid = 1'b0;
            s_ref_tvalid = 1'b0;
        end
        if (clr_s) begin
            m_match = 0; m_mismatch = 0; m_seq = 0; m_err = 0;
        end else if (fire_s) begin
            m_seq = (m_seq + 1) % 65536;
            if (mm) begin
                m_err = 1;
                if (m_mismatch < 65535) m_mismatch++;
            end else begin
                if (m_match < 65535) m_match++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the model advanced n cycles.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            driveInputs();
            @(negedge aclk);
            checkCycle();
            @(posedge aclk);
            #1;
            updateModel();
        end
    endtask

    initial begin
        aresetn      = 1'b0;
        clr          = 1'b0;
        m_sts_tready = 1'b1;
        s_crc_tdata  = 32'h0;
        s_ref_tdata  = 32'h0;
        flushModel();
        s_crc_tvalid = 1'b1;
        s_ref_tvalid = 1'b1;
        setKnobs(0, 0, 100, 0, 0);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_tvalid", {31'b0, m_sts_tvalid}, 0);
        checkOutput("rst_tdata", m_sts_tdata, 0);
        checkOutput("rst_crc_tready", {31'b0, s_crc_tready}, 0);
        checkOutput("rst_ref_tready", {31'b0, s_ref_tready}, 0);
        checkOutput("rst_match", {16'b0, match_cnt}, 0);
        checkOutput("rst_mismatch", {16'b0, mismatch_cnt}, 0);
        checkOutput("rst_err", {31'b0, err_sticky}, 0);
        s_crc_tvalid = 1'b0;
        s_ref_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        $display("[TB] matching then mismatching pair");
        setKnobs(100, 100, 100, 0, 0);
        forcePair(32'hDEADBEEF, 32'hDEADBEEF);
        applyStimulus(1);
        checkOutput("t1_tdata", m_sts_tdata, 32'h0000_0000);
        checkOutput("t1_match", {16'b0, match_cnt}, 1);
        checkOutput("t1_err", {31'b0, err_sticky}, 0);
        forcePair(32'h12345678, 32'h12345679);
        applyStimulus(1);
        checkOutput("t2_tdata", m_sts_tdata, 32'h8000_0001);
        checkOutput("t2_mismatch", {16'b0, mismatch_cnt}, 1);
        checkOutput("t2_err", {31'b0, err_sticky}, 1);
        forcePair(32'hCAFEF00D, 32'hCAFEF00D);
        applyStimulus(1);
        checkOutput("t2_err_held", {31'b0, err_sticky}, 1);
        checkOutput("t2_tdata3", m_sts_tdata, 32'h0000_0002);
        setKnobs(0, 0, 100, 0, 0);
        applyStimulus(2);

        $display("[TB] one-sided valid held off");
        setKnobs(100, 0, 100, 0, 0);
        applyStimulus(5);
        setKnobs(100, 100, 100, 0, 0);
        applyStimulus(1);
        setKnobs(0, 0, 100, 0, 0);
        applyStimulus(2);

        $display("[TB] sink backpressure");
        setKnobs(100, 100, 0, 30, 0);
        applyStimulus(10);
        setKnobs(100, 100, 100, 30, 0);
        applyStimulus(20);
        setKnobs(0, 0, 100, 0, 0);
        applyStimulus(3);

        $display("[TB] counter saturation");
        setKnobs(0, 0, 100, 0, 1000);
        applyStimulus(1);
        setKnobs(100, 100, 100, 0, 0);
        applyStimulus(65539);
        checkOutput("t5_match_sat", {16'b0, match_cnt}, 32'h0000_FFFF);
        checkOutput("t5_last_seq", {16'b0, m_sts_tdata[15:0]}, 32'h0000_0002);
        setKnobs(0, 0, 100, 0, 0);
        applyStimulus(2);

        $display("[TB] clear colliding with a mismatching fire");
        setKnobs(100, 100, 100, 0, 0);
        forcePair(32'h0000_0001, 32'h0000_0002);
        applyStimulus(1);
        forcePair(32'h0000_0003, 32'h0000_0004);
        setKnobs(100, 100, 100, 0, 1000);
        applyStimulus(1);
        checkOutput("t6_bit31", {31'b0, m_sts_tdata[31]}, 1);
        checkOutput("t6_mismatch", {16'b0, mismatch_cnt}, 0);
        checkOutput("t6_err", {31'b0, err_sticky}, 0);
        setKnobs(0, 0, 0, 0, 0);
        applyStimulus(2);
        checkOutput("t6_pre_tvalid", {31'b0, m_sts_tvalid}, 1);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_rst_tvalid", {31'b0, m_sts_tvalid}, 0);
        checkOutput("t6_rst_tready", {31'b0, s_crc_tready}, 0);
        flushModel();
        clr = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        $display("[TB] random traffic");
        for (int p = 0; p < 6; p++) begin
            setKnobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100),
                     $urandom_range(0, 50), $urandom_range(0, 20));
            applyStimulus(1500);
        end

        setKnobs(0, 0, 100, 0, 0);
        applyStimulus(5);
        checkOutput("final_drain", {31'b0, m_sts_tvalid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
